// File: rtl/uart_frame_scheduler_pkg.sv
// Shared types and byte-packing helpers for the UART frame scheduler.
// The optional watchdog is enabled with the UART_SCHED_TIMEOUT_EN macro.
package uart_frame_scheduler_pkg;

  localparam int DEFAULT_NUM_MODULES = 9;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_B1_REQ    = 3'd1,
    S_B1_DRAIN  = 3'd2,
    S_B2_REQ    = 3'd3,
    S_B2_DRAIN  = 3'd4,
    S_WAIT_TICK = 3'd5,
    S_SHOOT     = 3'd6
  } sched_state_e;

  function automatic logic [7:0] pack_byte1(input logic [11:0] idx);
    return idx[11:4];
  endfunction

  function automatic logic [7:0] pack_byte2(input logic [11:0] idx, input logic [3:0] id);
    return {idx[3:0], id};
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Frame request, UART TX fan-out and shoot signals of the scheduler.
// slave = scheduler view, master = surrounding logic / bench view.
interface uart_frame_scheduler_if
  import uart_frame_scheduler_pkg::*;
#(
  parameter int NUM_MODULES = DEFAULT_NUM_MODULES
);
  logic                   frame_valid;
  logic                   frame_ready;
  logic [11:0]            sin_index;
  logic [3:0]             uart_id;
  logic [NUM_MODULES-1:0] module_mask;
  logic                   period_tick;
  logic [7:0]             data_to_tx;
  logic [NUM_MODULES-1:0] start_tx;
  logic [NUM_MODULES-1:0] tx_busy;
  logic                   shoot;
  logic                   overrun;
  logic                   err_timeout;

  modport slave (
    input  frame_valid, sin_index, uart_id, module_mask, period_tick, tx_busy,
    output frame_ready, data_to_tx, start_tx, shoot, overrun, err_timeout
  );

  modport master (
    output frame_valid, sin_index, uart_id, module_mask, period_tick, tx_busy,
    input  frame_ready, data_to_tx, start_tx, shoot, overrun, err_timeout
  );
endinterface

// File: rtl/uart_frame_scheduler_sched_ack_tracker.sv
// Per-channel sticky acknowledge bits plus the all-acked / all-idle compares.
// One instance serves both bytes; the scheduler clears it between them.
module sched_ack_tracker
  import uart_frame_scheduler_pkg::*;
#(
  parameter int NUM_MODULES = DEFAULT_NUM_MODULES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_capture,
  input  logic                   i_clear,
  input  logic [NUM_MODULES-1:0] i_mask,
  input  logic [NUM_MODULES-1:0] i_busy,
  output logic [NUM_MODULES-1:0] o_ack_next,
  output logic                   o_all_acked,
  output logic                   o_all_idle
);
  logic [NUM_MODULES-1:0] r_ack;
  logic [NUM_MODULES-1:0] w_busy_en;

  assign w_busy_en   = i_busy & i_mask;
  // Compare includes this cycle's busy so start_tx drops on the same edge the last ack lands.
  assign o_ack_next  = r_ack | w_busy_en;
  assign o_all_acked = (o_ack_next == i_mask);
  assign o_all_idle  = (w_busy_en == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_clear) r_ack <= '0;
    else if (i_capture)   r_ack <= o_ack_next;
  end
endmodule

// File: rtl/uart_frame_scheduler.sv
// Broadcasts a two-byte sine/id frame to the enabled UART TX channels, then shoots on the next
// PWM period tick. Define UART_SCHED_TIMEOUT_EN to add a per-phase watchdog.
module uart_frame_scheduler
  import uart_frame_scheduler_pkg::*;
#(
  parameter int NUM_MODULES    = DEFAULT_NUM_MODULES,
  parameter int SHOOT_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic reset,
  uart_frame_scheduler_if.slave bus
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SHOOT_LEN) ? TIMEOUT_CYCLES : SHOOT_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  sched_state_e           r_state;
  logic [11:0]            r_idx;
  logic [3:0]             r_id;
  logic [NUM_MODULES-1:0] r_mask;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_frame_ready;
  logic [7:0]             r_data;
  logic [NUM_MODULES-1:0] r_start;
  logic                   r_shoot;
  logic                   r_overrun;
  logic                   r_err;

  logic                   w_in_req;
  logic                   w_sending;
  logic                   w_count_en;
  logic                   w_timeout;
  logic                   w_clear_ack;
  logic [NUM_MODULES-1:0] w_ack_next;
  logic                   w_all_acked;
  logic                   w_all_idle;

  assign w_in_req  = (r_state == S_B1_REQ) || (r_state == S_B2_REQ);
  assign w_sending = w_in_req || (r_state == S_B1_DRAIN) || (r_state == S_B2_DRAIN);

`ifdef UART_SCHED_TIMEOUT_EN
  assign w_count_en = (r_state == S_SHOOT) || w_sending;
  assign w_timeout  = w_sending && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_count_en = (r_state == S_SHOOT);
  assign w_timeout  = 1'b0;
`endif

  assign w_clear_ack = (w_in_req && w_all_acked) || w_timeout;

  sched_ack_tracker #(.NUM_MODULES(NUM_MODULES)) u_ack (
    .clk        (clk),
    .reset      (reset),
    .i_capture  (w_in_req),
    .i_clear    (w_clear_ack),
    .i_mask     (r_mask),
    .i_busy     (bus.tx_busy),
    .o_ack_next (w_ack_next),
    .o_all_acked(w_all_acked),
    .o_all_idle (w_all_idle)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_id          <= '0;
      r_mask        <= '0;
      r_cnt         <= '0;
      r_frame_ready <= 1'b0;
      r_data        <= '0;
      r_start       <= '0;
      r_shoot       <= 1'b0;
      r_overrun     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_overrun <= bus.period_tick && w_sending;
      r_err     <= 1'b0;
      if (w_count_en) r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          r_frame_ready <= 1'b1;
          if (bus.frame_valid && r_frame_ready) begin
            r_idx         <= bus.sin_index;
            r_id          <= bus.uart_id;
            r_mask        <= bus.module_mask;
            r_data        <= pack_byte1(bus.sin_index);
            r_frame_ready <= 1'b0;
            r_cnt         <= '0;
            if (bus.module_mask == '0) begin
              r_state <= S_WAIT_TICK;
            end else begin
              r_state <= S_B1_REQ;
              r_start <= bus.module_mask;
            end
          end
        end
        S_B1_REQ, S_B2_REQ: begin
          if (w_all_acked) begin
            r_start <= '0;
            r_cnt   <= '0;
            r_state <= (r_state == S_B1_REQ) ? S_B1_DRAIN : S_B2_DRAIN;
          end else begin
            r_start <= r_mask & ~w_ack_next;
          end
        end
        S_B1_DRAIN: begin
          if (w_all_idle) begin
            r_state <= S_B2_REQ;
            r_data  <= pack_byte2(r_idx, r_id);
            r_start <= r_mask;
            r_cnt   <= '0;
          end
        end
        S_B2_DRAIN: begin
          if (w_all_idle) begin
            r_state <= S_WAIT_TICK;
            r_cnt   <= '0;
          end
        end
        S_WAIT_TICK: begin
          if (bus.period_tick) begin
            r_state <= S_SHOOT;
            r_shoot <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_SHOOT: begin
          if (r_cnt == CNT_W'(SHOOT_LEN - 1)) begin
            r_state       <= S_IDLE;
            r_shoot       <= 1'b0;
            r_frame_ready <= 1'b1;
            r_cnt         <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= '0;
          r_shoot <= 1'b0;
          r_cnt   <= '0;
        end
      endcase

      // Watchdog abort is written last so it overrides any transition chosen above.
      if (w_timeout) begin
        r_state       <= S_IDLE;
        r_start       <= '0;
        r_err         <= 1'b1;
        r_frame_ready <= 1'b1;
        r_cnt         <= '0;
      end
    end
  end

  assign bus.frame_ready = r_frame_ready;
  assign bus.data_to_tx  = r_data;
  assign bus.start_tx    = r_start;
  assign bus.shoot       = r_shoot;
  assign bus.overrun     = r_overrun;
  assign bus.err_timeout = r_err;
endmodule

// File: doc/uart_frame_scheduler.md
Name: uart_frame_scheduler

Overview:
Sequences one inverter update: accepts a 12-bit sine index and 4-bit UART id from the SPI request path and broadcasts them as a two-byte frame to all enabled UART TX modules. It waits until every enabled module has accepted and finished each byte. It then fires the shoot pulse on the next PWM period tick. It sits between SPI_request_data and the uart_tx array in the top-level NORMAL_MODE path.

Parameters:
NUM_MODULES, 9, number of UART TX channels (1..16).
SHOOT_LEN, 4, shoot pulse width in clk cycles (>=1).
TIMEOUT_CYCLES, 4096, per-phase watchdog limit; used only with the optional feature.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
frame_valid  in  1  sin_index/uart_id valid.
frame_ready  out  1  scheduler can accept a frame.
sin_index  in  12  sine table index.
uart_id  in  4  target id carried in byte 2.
module_mask  in  NUM_MODULES  enabled channels; sampled at frame accept.
period_tick  in  1  one-cycle pulse at PWM period start.
data_to_tx  out  8  byte broadcast to all channels.
start_tx  out  NUM_MODULES  per-channel start request.
tx_busy  in  NUM_MODULES  per-channel busy from uart_tx.
shoot  out  1  shoot pulse.
overrun  out  1  one-cycle pulse when period_tick arrives while a frame is still sending.
err_timeout  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Clock is clk, reset is reset; reset is synchronous and active-high, with a single clock domain.
- Reset values: frame_ready=0 during reset and 1 on the first cycle after; data_to_tx=0; start_tx=0; shoot=0; overrun=0; err_timeout=0; state=IDLE; ack and counters=0.
- Reset asserted mid-operation aborts the frame at the next edge. start_tx and shoot drop immediately and no shoot is issued.
- States: IDLE, B1_REQ, B1_DRAIN, B2_REQ, B2_DRAIN, WAIT_TICK, SHOOT.
- IDLE:
  - frame_ready=1.
  - On frame_valid&frame_ready, latch sin_index, uart_id and module_mask (mask_q).
  - If mask_q==0, go to WAIT_TICK. Otherwise go to B1_REQ.
  - frame_ready is 1 only in IDLE.
- B1_REQ:
  - data_to_tx=idx_q[11:4].
  - start_tx[i]=mask_q[i]&~ack[i].
  - ack[i] sets sticky when tx_busy[i]=1 while mask_q[i]=1.
  - When ack==mask_q, start_tx goes 0, ack is cleared, and the state moves to B1_DRAIN.
- B1_DRAIN: when (tx_busy&mask_q)==0, go to B2_REQ. data_to_tx holds its value.
- B2_REQ / B2_DRAIN: identical to B1_REQ / B1_DRAIN, with data_to_tx={idx_q[3:0], id_q}. B2_DRAIN exits to WAIT_TICK.
- WAIT_TICK: on period_tick, go to SHOOT.
- SHOOT:
  - shoot=1 for exactly SHOOT_LEN cycles, starting the cycle after the tick.
  - Then return to IDLE with shoot=0.
- Disabled channels never see start_tx, and their tx_busy is ignored.
- Latency: an accepted frame drives start_tx on the next cycle.
- period_tick handling:
  - In B1_*/B2_*: pulse overrun for one cycle; the tick is not remembered, so shoot waits for the following tick.
  - In IDLE and SHOOT: ignored.
- A tick arriving on the same cycle WAIT_TICK is entered is not consumed; the tick must arrive while in WAIT_TICK.
- Changes to module_mask while a frame is in flight have no effect.

Optional Feature:
UART_SCHED_TIMEOUT_EN
- Defined: a counter resets on each state entry and increments in B1_REQ, B1_DRAIN, B2_REQ and B2_DRAIN. When it reaches TIMEOUT_CYCLES-1, the block:
  - drops start_tx to 0;
  - clears ack;
  - pulses err_timeout for one cycle;
  - returns to IDLE with no shoot.
- Undefined: no counter; err_timeout is tied to 0; waits are unbounded.

Decomposition:
- Shared package / config.vh: state encodings (3-bit localparams), byte-packing constants (BYTE1 = idx[11:4], BYTE2 = {idx[3:0], id}), and default NUM_MODULES.
- Sub-module: one natural sub-module, sched_ack_tracker, holding the per-channel sticky ack bits and the all-acked / all-idle compare. It is instantiated once and reused for both bytes.

Test Plan:
- Frame idx=0xABC, id=0x5, mask=all ones, each tx_busy rises 1 cycle after start and falls 200 cycles later -> data_to_tx=0xAB, then 0xC5; each channel sees exactly 2 start pulses; shoot high 4 cycles after the next tick; frame_ready returns.
- Skewed acks (channel 3 busy 5 cycles later than the others) -> start_tx[3] stays high until its busy rises; B1_DRAIN waits for channel 3's busy to fall.
- mask=0b000000101 -> only start_tx[0] and start_tx[2] toggle; tx_busy[8]=1 stuck has no effect; shoot fires.
- period_tick during B2_DRAIN -> overrun pulses once; shoot fires on the following tick, not the current one.
- reset asserted in B2_REQ -> next cycle start_tx=0 and shoot=0; frame_ready=1 after release; no shoot for that frame.
- With UART_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, tx_busy[1] never rises -> err_timeout pulses at cycle 64 of B1_REQ; state returns to IDLE; no shoot.
